// File: rtl/flood_fill_engine.sv
// rtl/flood_fill_engine.sv - Flood-It board update sequencer with flood mask and shared RAM port
//
// Purpose:
//   Owns the flood mask (cells connected to (0,0)). A move repaints the
//   flooded region in a new colour and grows the region by repeated row-major
//   sweeps until a sweep adds no cell. Board RAM is shared through req/gnt.
//
// Ports:
//   clock, reset_n          system clock, asynchronous active-low reset
//   start, new_size         new game pulse and requested board edge
//   move, move_color        player move pulse and chosen colour
//   size                    active (clamped) board edge
//   busy, done, win         sweeping flag, convergence pulse, full-board flag
//   moves, flood_color      accepted move count (saturating), region colour
//   mem_req, mem_gnt        board RAM request / arbiter grant
//   mem_en, mem_we          access strobe (only with grant), write select
//   mem_row, mem_col        cell address
//   mem_wdata, mem_rdata    write colour, read colour (one cycle after read)

module flood_fill_engine #(
  parameter int MAX_DIM = 26,
  parameter int CW      = 3,
  parameter int DW      = 5
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [DW-1:0] new_size,
  input  logic          move,
  input  logic [CW-1:0] move_color,
  output logic [DW-1:0] size,
  output logic          busy,
  output logic          done,
  output logic          win,
  output logic [7:0]    moves,
  output logic [CW-1:0] flood_color,
  output logic          mem_req,
  input  logic          mem_gnt,
  output logic          mem_en,
  output logic          mem_we,
  output logic [DW-1:0] mem_row,
  output logic [DW-1:0] mem_col,
  output logic [CW-1:0] mem_wdata,
  input  logic [CW-1:0] mem_rdata
);

  localparam int CELLS = MAX_DIM * MAX_DIM;
  localparam int IW    = $clog2(CELLS);
  localparam int CNT_W = $clog2(CELLS + 1);

  // The "next cell" step is folded into WT/WR so a cell costs two cycles
  // (read, evaluate) plus one when it needs repainting.
  typedef enum logic [2:0] {
    S_IDLE, S_INIT_RD, S_INIT_WT, S_RD, S_WT, S_WR, S_FIN
  } state_t;

  state_t state, state_next;

  logic [CELLS-1:0] mask;
  logic [CNT_W-1:0] mask_cnt;
  logic [DW-1:0]    row, col;
  logic             changed;

  logic [DW-1:0]    last;
  logic [IW-1:0]    cur_idx;
  logic [CNT_W-1:0] area;
  logic             nb;
  logic             adv;
  logic             set_bit;
  logic             sweep_end;

  function automatic logic [DW-1:0] clamp_size(input logic [DW-1:0] s);
    if (s < DW'(2))       return DW'(2);
    if (s > DW'(MAX_DIM)) return DW'(MAX_DIM);
    return s;
  endfunction

  assign last      = size - DW'(1);
  assign cur_idx   = IW'(row) * IW'(MAX_DIM) + IW'(col);
  assign area      = CNT_W'(size) * CNT_W'(size);
  assign sweep_end = (row == last) && (col == last);

  // Mask bits already set earlier in this sweep are visible here, so a
  // region can grow along rows/downwards within a single sweep.
  assign nb = ((row != '0)   && mask[cur_idx - IW'(MAX_DIM)]) ||
              ((row != last) && mask[cur_idx + IW'(MAX_DIM)]) ||
              ((col != '0)   && mask[cur_idx - IW'(1)])       ||
              ((col != last) && mask[cur_idx + IW'(1)]);

  assign mem_req   = busy;
  assign mem_en    = mem_gnt && (state == S_INIT_RD || state == S_RD || state == S_WR);
  assign mem_we    = (state == S_WR);
  assign mem_row   = row;
  assign mem_col   = col;
  assign mem_wdata = flood_color;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    adv        = 1'b0;
    set_bit    = 1'b0;
    case (state)
      S_IDLE:    if (move && (move_color != flood_color)) state_next = S_RD;
      S_INIT_RD: if (mem_gnt) state_next = S_INIT_WT;
      S_INIT_WT: state_next = S_RD;
      S_RD:      if (mem_gnt) state_next = S_WT;
      S_WT: begin
        if (mask[cur_idx] && (mem_rdata != flood_color)) begin
          state_next = S_WR;
        end else begin
          set_bit = !mask[cur_idx] && (mem_rdata == flood_color) && nb;
          adv     = 1'b1;
        end
      end
      S_WR:      if (mem_gnt) adv = 1'b1;
      S_FIN:     state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    // A cell added on the very last position still forces another sweep.
    if (adv) state_next = (sweep_end && !(changed || set_bit)) ? S_FIN : S_RD;
    if (start) state_next = S_INIT_RD;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask        <= '0;
      mask_cnt    <= '0;
      moves       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      win         <= 1'b0;
      size        <= DW'(MAX_DIM);
      flood_color <= '0;
      row         <= '0;
      col         <= '0;
      changed     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mask     <= CELLS'(1);
        mask_cnt <= CNT_W'(1);
        moves    <= '0;
        win      <= 1'b0;
        size     <= clamp_size(new_size);
        row      <= '0;
        col      <= '0;
        changed  <= 1'b0;
        busy     <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (move && (move_color != flood_color)) begin
              flood_color <= move_color;
              if (moves != 8'hFF) moves <= moves + 8'd1;
              row     <= '0;
              col     <= '0;
              changed <= 1'b0;
              busy    <= 1'b1;
            end
          end
          S_INIT_WT: begin
            flood_color <= mem_rdata;
            changed     <= 1'b0;
          end
          S_FIN: begin
            busy <= 1'b0;
            done <= 1'b1;
            win  <= (mask_cnt == area);
          end
          default: ;
        endcase
        if (set_bit) begin
          mask[cur_idx] <= 1'b1;
          mask_cnt      <= mask_cnt + CNT_W'(1);
          changed       <= 1'b1;
        end
        if (adv) begin
          if (col == last) begin
            col <= '0;
            if (row == last) begin
              row     <= '0;
              changed <= 1'b0;
            end else begin
              row <= row + DW'(1);
            end
          end else begin
            col <= col + DW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_flood_fill_engine.sv
// tb/tb_flood_fill_engine.sv - self-checking bench for flood_fill_engine

module tb_flood_fill_engine;

  localparam int MD = 26;
  localparam int CW = 3;
  localparam int DW = 5;

  logic          clock = 1'b0;
  logic          reset_n, start, move;
  logic [DW-1:0] new_size;
  logic [CW-1:0] move_color;
  logic [DW-1:0] size;
  logic          busy, done, win;
  logic [7:0]    moves;
  logic [CW-1:0] flood_color;
  logic          mem_req;
  logic          mem_gnt = 1'b1;
  logic          mem_en, mem_we;
  logic [DW-1:0] mem_row, mem_col;
  logic [CW-1:0] mem_wdata;
  logic [CW-1:0] mem_rdata = '0;

  always #5 clock = ~clock;

  flood_fill_engine #(.MAX_DIM(MD), .CW(CW), .DW(DW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .new_size(new_size),
    .move(move), .move_color(move_color), .size(size), .busy(busy),
    .done(done), .win(win), .moves(moves), .flood_color(flood_color),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_en(mem_en), .mem_we(mem_we),
    .mem_row(mem_row), .mem_col(mem_col), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Board RAM with 1-cycle read latency; ld_req copies img in one cycle.
  logic [CW-1:0] ram [MD][MD];
  logic [CW-1:0] img [MD][MD];
  logic          ld_req = 1'b0;
  int            n00 = 0;

  always @(posedge clock) begin
    if (ld_req) begin
      for (int r = 0; r < MD; r++)
        for (int c = 0; c < MD; c++) ram[r][c] <= img[r][c];
    end else if (mem_en) begin
      if (mem_we) ram[mem_row][mem_col] <= mem_wdata;
      else begin
        mem_rdata <= ram[mem_row][mem_col];
        if (mem_row == 0 && mem_col == 0) n00 <= n00 + 1;
      end
    end
  end

  // 0: permanent grant, 1: random 50%, 2: held low
  int gnt_mode = 0;
  always @(posedge clock) begin
    #1;
    case (gnt_mode)
      0:       mem_gnt = 1'b1;
      1:       mem_gnt = ($urandom_range(0, 1) == 1);
      default: mem_gnt = 1'b0;
    endcase
  end

  // Behavioural model: expected board, flood mask, counters.
  int mb [MD][MD];
  bit mm [MD][MD];
  int msize, mflood, mmoves, mcount;
  bit exp_armed;

  int n_cmp = 0;
  int n_fail = 0;

  bit            p_wr_stall;
  logic [DW-1:0] p_row, p_col;
  logic [CW-1:0] p_wdata;

  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  function automatic int clamp(input int s);
    if (s < 2) return 2;
    if (s > MD) return MD;
    return s;
  endfunction

  // Connected component of (0,0) in colour k over the model board.
  task automatic bfs(input int k);
    int q[$];
    int p, r, c, nr, nc;
    for (int i = 0; i < MD; i++)
      for (int j = 0; j < MD; j++) mm[i][j] = 1'b0;
    mm[0][0] = 1'b1;
    mcount = 1;
    q.push_back(0);
    while (q.size() > 0) begin
      p = q.pop_front();
      r = p / MD;
      c = p % MD;
      for (int d = 0; d < 4; d++) begin
        nr = r + ((d == 0) ? -1 : (d == 1) ? 1 : 0);
        nc = c + ((d == 2) ? -1 : (d == 3) ? 1 : 0);
        if (nr >= 0 && nr < msize && nc >= 0 && nc < msize)
          if (!mm[nr][nc] && mb[nr][nc] == k) begin
            mm[nr][nc] = 1'b1;
            mcount++;
            q.push_back(nr * MD + nc);
          end
      end
    end
  endtask

  task automatic model_reset();
    msize = MD; mflood = 0; mmoves = 0; mcount = 0;
    for (int i = 0; i < MD; i++)
      for (int j = 0; j < MD; j++) mm[i][j] = 1'b0;
  endtask

  task automatic check_done();
    int bad;
    chk("done_busy", busy, 0);
    chk("done_size", size, msize);
    chk("done_flood_color", flood_color, mflood);
    chk("done_moves", moves, mmoves);
    chk("done_win", win, (mcount == msize * msize) ? 1 : 0);
    bad = 0;
    for (int r = 0; r < msize; r++)
      for (int c = 0; c < msize; c++)
        if (ram[r][c] != mb[r][c]) bad++;
    chk("done_ram_cells_wrong", bad, 0);
    bad = 0;
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++)
        if (dut.mask[r * MD + c] != ((r < msize && c < msize) ? mm[r][c] : 1'b0)) bad++;
    chk("done_mask_bits_wrong", bad, 0);
  endtask

  // One cycle, checked at the falling edge.
  task automatic tick();
    @(negedge clock);
    if (!reset_n) begin
      p_wr_stall = 1'b0;
    end else begin
      chk("mem_req_eq_busy", mem_req, busy);
      chk("mem_en_without_gnt", (mem_en && !mem_gnt) ? 1 : 0, 0);
      if (p_wr_stall && !start)
        chk("stall_addr_data_stable",
            (mem_row == p_row && mem_col == p_col && mem_wdata == p_wdata) ? 1 : 0, 1);
      p_wr_stall = busy && mem_we && !mem_gnt;
      p_row = mem_row; p_col = mem_col; p_wdata = mem_wdata;
      if (done) begin
        if (!exp_armed) fail_now("unexpected_done");
        else check_done();
        exp_armed = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (exp_armed && n < limit) begin
      tick();
      n++;
    end
    if (exp_armed) begin
      fail_now("done_timeout");
      exp_armed = 1'b0;
    end
  endtask

  task automatic load();
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) img[r][c] = CW'(mb[r][c]);
    ld_req = 1'b1;
    tick();
    ld_req = 1'b0;
  endtask

  task automatic fill(input int k);
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) mb[r][c] = k;
  endtask

  task automatic snake_board();
    fill(1);
    mb[0][0] = 0;
    for (int c = 1; c < 5; c++) mb[0][c] = 3;
    mb[1][4] = 3;
    for (int c = 0; c < 5; c++) mb[2][c] = 3;
    mb[3][0] = 3;
    for (int c = 0; c < 5; c++) mb[4][c] = 3;
  endtask

  task automatic arm_start(input int sz);
    msize = clamp(sz);
    mflood = mb[0][0];
    mmoves = 0;
    bfs(mflood);
    exp_armed = 1'b1;
  endtask

  task automatic arm_move(input int k);
    for (int r = 0; r < msize; r++)
      for (int c = 0; c < msize; c++)
        if (mm[r][c]) mb[r][c] = k;
    mflood = k;
    if (mmoves < 255) mmoves++;
    bfs(k);
    exp_armed = 1'b1;
  endtask

  task automatic pulse_start(input int sz);
    new_size = DW'(sz);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_move(input int k);
    move_color = CW'(k);
    move = 1'b1;
    tick();
    move = 1'b0;
  endtask

  task automatic check_reset_values();
    chk("rst_size", size, MD);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_win", win, 0);
    chk("rst_moves", moves, 0);
    chk("rst_flood_color", flood_color, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_row", mem_row, 0);
    chk("rst_mem_col", mem_col, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
  endtask

  initial begin
    int s, nb;
    reset_n = 1'b0; start = 1'b0; move = 1'b0;
    new_size = '0; move_color = '0;
    exp_armed = 1'b0; p_wr_stall = 1'b0;
    model_reset();
    repeat (3) tick();
    check_reset_values();
    reset_n = 1'b1;
    tick();

    // 1: uniform 3x3 board
    fill(2); load();
    arm_start(3); pulse_start(3); wait_done(500);
    chk("t1_win", win, 1);
    chk("t1_flood_color", flood_color, 2);
    chk("t1_moves", moves, 0);

    // 2: 2x2 [[0,1],[1,1]], then move 1
    fill(1); mb[0][0] = 0; load();
    arm_start(2); pulse_start(2); wait_done(200);
    chk("t2_start_win", win, 0);
    chk("t2_start_flood", flood_color, 0);
    arm_move(1); pulse_move(1); wait_done(200);
    chk("t2_moves", moves, 1);
    chk("t2_ram00", ram[0][0], 1);
    chk("t2_win", win, 1);

    // 3: snake path needs six sweeps
    snake_board(); load();
    arm_start(5); pulse_start(5); wait_done(500);
    s = n00;
    arm_move(3); pulse_move(3); wait_done(3000);
    chk("t3_sweeps", n00 - s, 6);
    chk("t3_model_region", mcount, 17);
    chk("t3_win", win, 0);

    // 4: same colour rejected; move while busy ignored
    pulse_move(3);
    nb = 0;
    repeat (10) begin tick(); nb += busy; end
    chk("t4_reject_busy_cycles", nb, 0);
    chk("t4_reject_moves", moves, 1);
    arm_move(1); pulse_move(1);
    tick();
    chk("t4_busy_after_move", busy, 1);
    pulse_move(2);
    wait_done(3000);
    chk("t4_moves", moves, 2);
    chk("t4_win", win, 1);
    chk("t4_flood_color", flood_color, 1);

    // 5: random grant gives the same board as a permanent one
    snake_board(); load();
    gnt_mode = 1;
    arm_start(5); pulse_start(5); wait_done(3000);
    arm_move(3); pulse_move(3); wait_done(8000);
    chk("t5_moves", moves, 1);
    gnt_mode = 0;

    // 6a: NEW_SIZE=31 clamps to 26
    fill(5); load();
    arm_start(31); pulse_start(31); wait_done(6000);
    chk("t6_clamp_hi_size", size, 26);
    chk("t6_clamp_hi_win", win, 1);

    // 6b: START aborts a sweep; grant held low while the board is replaced
    pulse_move(6);
    repeat (8) tick();
    chk("t6_busy_before_abort", busy, 1);
    gnt_mode = 2;
    pulse_start(3);
    fill(4); mb[2][2] = 1; load();
    arm_start(3);
    gnt_mode = 0;
    wait_done(500);
    chk("t6_abort_moves", moves, 0);
    chk("t6_abort_win", win, 0);

    // 6c: reset mid-sweep, then NEW_SIZE=0 clamps to 2
    pulse_move(1);
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    check_reset_values();
    model_reset();
    reset_n = 1'b1;
    tick();
    fill(6); load();
    arm_start(0); pulse_start(0); wait_done(200);
    chk("t6_clamp_lo_size", size, 2);
    chk("t6_clamp_lo_flood", flood_color, 6);
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
